// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: character codes, segment patterns and dwell states for the scan decoder
package seven_seg_pkg;
  typedef enum logic [4:0] {
    CH_0 = 5'd0, CH_1 = 5'd1, CH_2 = 5'd2, CH_3 = 5'd3, CH_4 = 5'd4,
    CH_5 = 5'd5, CH_6 = 5'd6, CH_7 = 5'd7, CH_8 = 5'd8, CH_9 = 5'd9,
    CH_A = 5'd10, CH_B = 5'd11, CH_C = 5'd12, CH_D = 5'd13, CH_E = 5'd14,
    CH_F = 5'd15, CH_P = 5'd16, CH_G = 5'd17, CH_N = 5'd18, CH_T = 5'd19,
    CH_SPACE = 5'd20, CH_UNKNOWN = 5'd31
  } seven_seg_char_e;
  localparam seven_seg_char_e CHAR_SPACE = CH_SPACE;
  localparam seven_seg_char_e CHAR_UNKNOWN = CH_UNKNOWN;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  localparam logic [6:0] SEG_P = 7'b1100111;
  localparam logic [6:0] SEG_G = 7'b1011110;
  localparam logic [6:0] SEG_N = 7'b1110110;
  localparam logic [6:0] SEG_T = 7'b0001111;
  localparam logic [6:0] SEG_SPACE = 7'b0000000;
  typedef enum logic {WAIT_STABLE, CAPTURED} dwell_state_e;
endpackage

// File: rtl/seven_seg_char_decode.sv
// seven_seg_char_decode: maps an abcdefg segment pattern to its character code
module seven_seg_char_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0]      pattern,
  output seven_seg_char_e code,
  output logic            unknown
);
  always_comb begin
    case (pattern)
      SEG_0: code = CH_0;
      SEG_1: code = CH_1;
      SEG_2: code = CH_2;
      SEG_3: code = CH_3;
      SEG_4: code = CH_4;
      SEG_5: code = CH_5;
      SEG_6: code = CH_6;
      SEG_7: code = CH_7;
      SEG_8: code = CH_8;
      SEG_9: code = CH_9;
      SEG_A: code = CH_A;
      SEG_B: code = CH_B;
      SEG_C: code = CH_C;
      SEG_D: code = CH_D;
      SEG_E: code = CH_E;
      SEG_F: code = CH_F;
      SEG_P: code = CH_P;
      SEG_G: code = CH_G;
      SEG_N: code = CH_N;
      SEG_T: code = CH_T;
      SEG_SPACE: code = CHAR_SPACE;
      default: code = CHAR_UNKNOWN;
    endcase
    unknown = code == CHAR_UNKNOWN;
  end
endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: recovers whole character frames from a multiplexed seven-segment bus
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int w_digit = 8,
  parameter int settle_cycles = 4,
  parameter int seg_active_low = 0,
  parameter int digit_active_low = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           abcdefgh,
  input  logic [w_digit-1:0]   digit,
  output logic [5*w_digit-1:0] chars,
  output logic [w_digit-1:0]   dps,
  output logic                 frame_valid,
  output logic                 frame_error,
  output logic                 strobe_error
);
  logic [7:0] seg_q, seg_d, stable_cnt_q, stable_cnt_d;
  logic [w_digit-1:0] digit_q, digit_d, seen_q, seen_d, shadow_dp_q, shadow_dp_d, dps_q, dps_d;
  logic [w_digit-1:0][4:0] shadow_char_q, shadow_char_d, chars_q, chars_d;
  logic shadow_err_q, shadow_err_d, frame_valid_q, frame_valid_d;
  logic frame_error_q, frame_error_d, strobe_error_q, strobe_error_d;
  dwell_state_e state_q, state_d;
  seven_seg_char_e code;
  logic unknown, same, capture, lit, multi, done;
  seven_seg_char_decode u_decode (.pattern(seg_q[7:1]), .code(code), .unknown(unknown));
  always_comb begin
    seg_d = seg_active_low != 0 ? ~abcdefgh : abcdefgh;
    digit_d = digit_active_low != 0 ? ~digit : digit;
    same = {seg_d, digit_d} == {seg_q, digit_q};
    stable_cnt_d = !same ? 8'd0 : stable_cnt_q == 8'(settle_cycles) ? stable_cnt_q : stable_cnt_q + 8'd1;
    // stable_cnt_q describes the pair currently held in seg_q/digit_q
    capture = state_q == WAIT_STABLE && stable_cnt_q >= 8'(settle_cycles - 1);
    lit = capture && $onehot(digit_q);
    multi = capture && !$onehot0(digit_q);
    state_d = !same ? WAIT_STABLE : capture ? CAPTURED : state_q;
    done = &seen_q;
    seen_d = done ? '0 : seen_q;
    shadow_char_d = shadow_char_q;
    shadow_dp_d = shadow_dp_q;
    for (int i = 0; i < w_digit; i++)
      if (lit && digit_q[i]) begin
        shadow_char_d[i] = code;
        shadow_dp_d[i] = seg_q[0];
        seen_d[i] = 1'b1;
      end
    shadow_err_d = (done ? 1'b0 : shadow_err_q) | multi | (lit && unknown);
    chars_d = done ? shadow_char_q : chars_q;
    dps_d = done ? shadow_dp_q : dps_q;
    frame_error_d = done ? shadow_err_q : frame_error_q;
    frame_valid_d = done;
    strobe_error_d = multi;
  end
  always_ff @(posedge clk)
    if (rst) begin
      seg_q <= '0;
      digit_q <= '0;
      stable_cnt_q <= '0;
      state_q <= WAIT_STABLE;
      seen_q <= '0;
      shadow_char_q <= {w_digit{CHAR_SPACE}};
      shadow_dp_q <= '0;
      shadow_err_q <= 1'b0;
      chars_q <= {w_digit{CHAR_SPACE}};
      dps_q <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      strobe_error_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      digit_q <= digit_d;
      stable_cnt_q <= stable_cnt_d;
      state_q <= state_d;
      seen_q <= seen_d;
      shadow_char_q <= shadow_char_d;
      shadow_dp_q <= shadow_dp_d;
      shadow_err_q <= shadow_err_d;
      chars_q <= chars_d;
      dps_q <= dps_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      strobe_error_q <= strobe_error_d;
    end
  assign chars = chars_q;
  assign dps = dps_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign strobe_error = strobe_error_q;
endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receive side of the multiplexed seven-segment display interface.
- Monitors a time-multiplexed `abcdefgh` / `digit` bus, the same bus the lab display drivers generate.
- Waits until each digit dwell is stable, decodes its segment pattern back to a character code, and assembles a full frame of `w_digit` characters.
- Used as an on-board loopback checker and in benches to read back what the display shows, e.g. for UART echo.

Parameters:
- w_digit, 8, number of digit strobes; frame width.
- settle_cycles, 4, consecutive identical samples required before a dwell is captured; legal range 1..255.
- seg_active_low, 0, when 1 the segment inputs are inverted at the input register.
- digit_active_low, 0, when 1 the digit inputs are inverted at the input register.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- abcdefgh  input  8  segment bus; bit 7 = a … bit 1 = g, bit 0 = h (decimal point).
- digit  input  w_digit  digit strobes; one-hot when a digit is lit.
- chars  output  5*w_digit  decoded character codes; digit i occupies bits [5i+4:5i].
- dps  output  w_digit  decimal-point state per digit.
- frame_valid  output  1  one-cycle pulse when `chars` / `dps` / `frame_error` update.
- frame_error  output  1  valid with `frame_valid`: the frame contained a bad strobe or an unknown pattern.
- strobe_error  output  1  one-cycle pulse when a stable multi-hot `digit` is detected.

Behaviour:
- Input stage:
  - `seg_q` and `digit_q` are registered after the polarity inversion. One cycle of latency; no other synchronisation is needed (single clock).
- Stability counter:
  - `stable_cnt` counts cycles in which `{seg_q, digit_q}` equals the previous sample.
  - Any change resets it to 0 and clears `captured_flag`.
  - The count saturates at `settle_cycles`.
- Dwell FSM, states WAIT_STABLE and CAPTURED:
  - WAIT_STABLE -> CAPTURED when `stable_cnt` reaches `settle_cycles-1` (the pair has been identical for `settle_cycles` samples).
  - On that transition:
    - `digit_q` == 0: blanking interval; no capture, no error.
    - `digit_q` one-hot, index k:
      - `shadow_char[k]` <= decode(`seg_q[7:1]`);
      - `shadow_dp[k]` <= `seg_q[0]`;
      - `seen[k]` <= 1;
      - an unknown pattern sets `shadow_err`.
    - `digit_q` multi-hot: `strobe_error` pulses for 1 cycle, `shadow_err` is set, nothing is captured.
  - CAPTURED -> WAIT_STABLE on any input change. There is exactly one capture per dwell, however long the dwell lasts.
- Re-capture of an already-seen digit before the frame completes overwrites its shadow entry (latest wins).
- Frame completion, in the cycle after the capture that makes `seen` all-ones:
  - `chars` <= `shadow_char`, `dps` <= `shadow_dp`, `frame_error` <= `shadow_err`;
  - `frame_valid` = 1 for exactly that cycle;
  - `seen` and `shadow_err` clear at the same edge.
  - If a new capture coincides with the clear, that capture is kept and is the first entry of the next frame.
- Outputs hold between frames; they never expose partially assembled data.
- Decode is on `abcdefgh[7:1]`, written as abcdefg. Codes:
  - 0..9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
  - A=10 1110111, b=11 0011111, C=12 1001110, d=13 0111101, E=14 1001111, F=15 1000111.
  - P=16 1100111, G=17 1011110, N=18 1110110, T=19 0001111, space=20 0000000.
  - Any other pattern = 31 (unknown).
- Reset values:
  - `chars` all 20 (space); `dps`, `frame_valid`, `frame_error`, `strobe_error` all 0;
  - `seen`, `shadow_err`, `stable_cnt` cleared; FSM in WAIT_STABLE.
- Reset asserted mid-frame discards all shadow data; no `frame_valid` is produced for the partial frame.

Decomposition:
- Package `seven_seg_pkg`:
  - `seven_seg_char_e`, a 5-bit enum of the codes above;
  - the 7-bit pattern constants;
  - `CHAR_UNKNOWN` and `CHAR_SPACE`.
- Sub-module `seven_seg_char_decode`: purely combinational, pattern in, code plus `unknown` flag out. It is reused by future UART/graphics echo blocks.

Test Plan:
- Reset, then scan F,P,G,A on digits 3..0 and space on digits 7..4, 6 cycles per dwell with `settle_cycles`=4 -> one `frame_valid` pulse. `chars` = {20,20,20,20,15,16,17,10} (digit7..digit0), `frame_error`=0.
- Dwell held only 3 cycles on digit 2 -> no capture; `frame_valid` stays 0 until digit 2 is later held ≥4 cycles.
- Stable `digit`=8'b0000_0011 for 5 cycles -> `strobe_error` pulses once. The next completed frame has `frame_error`=1.
- Pattern 1010101 on digit 0 -> `chars[4:0]`=31 and `frame_error`=1 at frame completion.
- `digit`=0 blanking gaps of 10 cycles between dwells -> no error; frame still completes with the correct `chars`.
- Assert `rst` after 5 of 8 digits are captured, then scan a full frame -> the single `frame_valid` carries only the post-reset data.
